capture_period_multi: RTL and testbench
=======================================

CAPTURE_PERIOD_MULTI -- requirements
Module: capture_period_multi

Interface
REQ-001 Parameter CH, default 2: number of independent capture channels (1..16).
REQ-002 Parameter FLT_W, default 4: width of the glitch-filter counter and threshold.
REQ-003 Parameter TS_W, default 24: width of the period counter and of each captured period.
REQ-004 Parameter DEPTH, default 3: number of captured periods held per channel (1..8).
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 ena  in  1  time-base tick; the filter counter and period counter advance only on cycles with ena=1.
REQ-008 d  in  CH  raw input pins, already synchronised to clk.
REQ-009 flt_val  in  FLT_W  filter threshold, shared by all channels.
REQ-010 edge_mode  in  2*CH  per channel: 00 off, 01 rising, 10 falling, 11 both edges.
REQ-011 clr  in  CH  per-channel synchronous clear of the capture history.
REQ-012 filtered  out  CH  filtered pin level.
REQ-013 edge_evt  out  CH  one-clk pulse for each qualified edge.
REQ-014 stb  out  CH  one-clk pulse when a new period is pushed into the history.
REQ-015 period  out  CH*DEPTH*TS_W  history; channel i, slot k at [(i*DEPTH+k)*TS_W +: TS_W]; slot 0 is the newest.
REQ-016 valid_cnt  out  CH*4  per-channel count of valid history slots, saturating at DEPTH.
REQ-017 ovf  out  CH  sticky flag: a saturated period was pushed.

Function
REQ-018 Filter, per channel, d==filtered: filter count is cleared to 0 on every cycle, regardless of ena.
REQ-019 Filter, per channel, ena=1 and d!=filtered: if count==flt_val, then filtered<=d and count<=0; otherwise count<=count+1.
REQ-020 Filter, flt_val=0: filtered follows d on the first ena cycle after d changes; a pulse shorter than flt_val+1 ena cycles never reaches filtered.
REQ-021 Edge: a change of filtered that matches edge_mode asserts edge_evt for exactly the next clk cycle; latency from the filtered transition is 1 clk.
REQ-022 Period counter, per channel: increments on ena cycles and saturates at 2^TS_W-1 (no wrap).
REQ-023 On an edge_evt cycle the period counter loads 1 if ena=1 that cycle, else 0.
REQ-024 Arming: the first edge_evt after reset, clr, or mode 00 sets an internal armed flag; it pushes nothing and asserts no stb.
REQ-025 Push: an edge_evt while armed shifts slot k into slot k+1, discards the oldest slot, and loads slot 0 with the pre-reload counter value.
REQ-026 Push, same cycle: stb asserts for 1 clk concurrent with edge_evt; valid_cnt increments, saturating at DEPTH.
REQ-027 ovf[i] is set when the pushed value equals 2^TS_W-1; it stays set until clr or reset.
REQ-028 edge_mode 00: counter is held at 0, armed is cleared, no edge_evt or stb is produced; history and valid_cnt are retained.
REQ-029 A mode change takes effect from the next clk cycle; filtered tracking is independent of mode.
REQ-030 clr[i] clears channel i's history, valid_cnt, ovf, armed flag and counter in one cycle.
REQ-031 clr[i] has priority over a coincident edge_evt; the edge is dropped (no push, no arm), but edge_evt still pulses.
REQ-032 Channels are fully independent; simultaneous events on several channels are all processed in the same cycle.

Reset
REQ-033 rst=0 asynchronously forces the following outputs to 0: filtered, edge_evt, stb, period, valid_cnt, ovf.
REQ-034 rst=0 also asynchronously forces all filter counters, period counters and armed flags to 0.
REQ-035 Reset assertion mid-capture discards all history; after rst returns to 1, operation restarts unarmed.

Verification
REQ-036 flt_val=3, ena=1 constantly, ch0 d pulse high for 3 clk -> filtered[0] stays 0; pulse of 4 clk -> filtered[0] rises on the 4th cycle, edge_evt[0] 1 clk later.
REQ-037 mode 01, ena=1, flt_val=0, rising edges 100 clk apart, three edges -> first edge arms only; slot0=100, slot1=100; valid_cnt=2; stb pulsed twice.
REQ-038 DEPTH=3, mode 11, edges at intervals 10,20,30,40 clk -> slots {40,30,20}; valid_cnt=3.
REQ-039 TS_W=8, mode 01, edges 300 clk apart -> slot0=255, ovf=1; clr pulse -> ovf=0, valid_cnt=0, history 0.
REQ-040 clr and edge_evt on the same cycle on ch1, ch0 edge concurrently -> ch1 not armed and no stb; ch0 pushes normally.
REQ-041 rst low for 1 clk mid-measurement -> all outputs 0 immediately; the next edge only arms.

Source files
------------

// File: rtl/capture_period_multi.sv
// Multi-channel input capture: per-channel glitch filter, edge qualification,
// and a saturating period counter that pushes edge-to-edge periods into a short history.
module capture_period_multi #(
  parameter int CH    = 2,
  parameter int FLT_W = 4,
  parameter int TS_W  = 24,
  parameter int DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [CH-1:0]             d,
  input  logic [FLT_W-1:0]          flt_val,
  input  logic [2*CH-1:0]           edge_mode,
  input  logic [CH-1:0]             clr,
  output logic [CH-1:0]             filtered,
  output logic [CH-1:0]             edge_evt,
  output logic [CH-1:0]             stb,
  output logic [CH*DEPTH*TS_W-1:0]  period,
  output logic [CH*4-1:0]           valid_cnt,
  output logic [CH-1:0]             ovf
);

  localparam logic [TS_W-1:0] CNT_MAX = {TS_W{1'b1}};
  localparam logic [3:0]      DEPTH_V = 4'(DEPTH);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [FLT_W-1:0] flt_cnt;
    logic             filt_q;
    logic             filt_prev;
    logic             evt_q;
    logic             armed;
    logic             ovf_q;
    logic [TS_W-1:0]  per_cnt;
    logic [3:0]       vcnt;
    logic [TS_W-1:0]  hist [DEPTH];
    logic [1:0]       mode;
    logic             mode_off;
    logic             evt_nxt;
    logic             push;

    assign mode     = edge_mode[2*i +: 2];
    assign mode_off = (mode == 2'b00);
    assign evt_nxt  = ~mode_off & ((mode[0] &  filt_q & ~filt_prev) |
                                   (mode[1] & ~filt_q &  filt_prev));
    // A push needs an arming edge first; clr drops the edge but not the edge_evt pulse.
    assign push     = evt_q & armed & ~clr[i] & ~mode_off;

    // Stage 0: glitch filter and edge qualification
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        flt_cnt   <= '0;
        filt_q    <= 1'b0;
        filt_prev <= 1'b0;
        evt_q     <= 1'b0;
      end else begin
        filt_prev <= filt_q;
        evt_q     <= evt_nxt;
        if (d[i] == filt_q) begin
          flt_cnt <= '0;
        end else if (ena) begin
          if (flt_cnt == flt_val) begin
            filt_q  <= d[i];
            flt_cnt <= '0;
          end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
          end
        end
      end
    end

    // Stage 1: period counter, arming and history shift
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        per_cnt <= '0;
        armed   <= 1'b0;
        vcnt    <= '0;
        ovf_q   <= 1'b0;
        for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
      end else if (clr[i]) begin
        per_cnt <= '0;
        armed   <= 1'b0;
        vcnt    <= '0;
        ovf_q   <= 1'b0;
        for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
      end else if (mode_off) begin
        per_cnt <= '0;
        armed   <= 1'b0;
      end else begin
        if (evt_q) begin
          per_cnt <= {{(TS_W-1){1'b0}}, ena};
          armed   <= 1'b1;
        end else if (ena && per_cnt != CNT_MAX) begin
          per_cnt <= per_cnt + TS_W'(1);
        end
        if (push) begin
          hist[0] <= per_cnt;
          for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
          if (vcnt != DEPTH_V) vcnt <= vcnt + 4'd1;
          if (per_cnt == CNT_MAX) ovf_q <= 1'b1;
        end
      end
    end

    assign filtered[i]        = filt_q;
    assign edge_evt[i]        = evt_q;
    assign stb[i]             = push;
    assign valid_cnt[i*4 +: 4] = vcnt;
    assign ovf[i]             = ovf_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      assign period[(i*DEPTH+k)*TS_W +: TS_W] = hist[k];
    end
  end

endmodule

// File: tb/tb_capture_period_multi.sv
// Directed bench for capture_period_multi: filter vector table plus hand-written
// capture, saturation, clear-priority and reset sequences.
module tb_capture_period_multi;

  localparam int CH    = 2;
  localparam int FLT_W = 4;
  localparam int TS_W  = 8;
  localparam int DEPTH = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ena;
  logic [CH-1:0]            d;
  logic [FLT_W-1:0]         flt_val;
  logic [2*CH-1:0]          edge_mode;
  logic [CH-1:0]            clr;
  logic [CH-1:0]            filtered;
  logic [CH-1:0]            edge_evt;
  logic [CH-1:0]            stb;
  logic [CH*DEPTH*TS_W-1:0] period;
  logic [CH*4-1:0]          valid_cnt;
  logic [CH-1:0]            ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int stb_tot0 = 0;
  int stb_tot1 = 0;
  int base0, base1;

  capture_period_multi #(.CH(CH), .FLT_W(FLT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .d(d), .flt_val(flt_val),
    .edge_mode(edge_mode), .clr(clr), .filtered(filtered), .edge_evt(edge_evt),
    .stb(stb), .period(period), .valid_cnt(valid_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stb[0]) stb_tot0 <= stb_tot0 + 1;
    if (stb[1]) stb_tot1 <= stb_tot1 + 1;
  end

  typedef struct {
    logic d0;
    logic exp_filt;
    logic exp_evt;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [TS_W-1:0] slot(input int ch, input int k);
    return period[(ch*DEPTH+k)*TS_W +: TS_W];
  endfunction

  function automatic logic [3:0] vc(input int ch);
    return valid_cnt[ch*4 +: 4];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rising edge on ch now, d high for half of n cycles, next call starts n cycles later.
  task automatic gap(input int ch, input int n);
    d[ch] = 1'b1;
    repeat (n/2) @(posedge clk);
    #1;
    d[ch] = 1'b0;
    repeat (n - n/2) @(posedge clk);
    #1;
  endtask

  task automatic tog(input int ch, input int n);
    d[ch] = ~d[ch];
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // d0 pattern, expected filtered[0], expected edge_evt[0]; flt_val=3, ch0 rising only
    tbl[0]  = '{1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0};

    rst = 1'b1; ena = 1'b1; d = '0; flt_val = 4'd3; edge_mode = 4'b0001; clr = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset filtered", filtered, 0);
    chk("reset edge_evt", edge_evt, 0);
    chk("reset stb", stb, 0);
    chk("reset period", period, 0);
    chk("reset valid_cnt", valid_cnt, 0);
    chk("reset ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Glitch filter and edge timing
    for (int s = 0; s < 16; s++) begin
      d[0] = tbl[s].d0;
      @(posedge clk);
      #1;
      chk($sformatf("filter step %0d filtered", s), filtered[0], tbl[s].exp_filt);
      chk($sformatf("filter step %0d edge_evt", s), edge_evt[0], tbl[s].exp_evt);
      chk($sformatf("filter step %0d stb", s), stb, 0);
    end

    clr = 2'b11;
    @(posedge clk);
    #1 clr = 2'b00;
    chk("post clr valid_cnt", valid_cnt, 0);

    // Three rising edges 100 clk apart
    flt_val = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    base0 = stb_tot0;
    gap(0, 100);
    chk("arm only valid_cnt", vc(0), 0);
    chk("arm only stb count", stb_tot0 - base0, 0);
    gap(0, 100);
    gap(0, 100);
    chk("r037 slot0", slot(0, 0), 100);
    chk("r037 slot1", slot(0, 1), 100);
    chk("r037 slot2", slot(0, 2), 0);
    chk("r037 valid_cnt", vc(0), 2);
    chk("r037 stb count", stb_tot0 - base0, 2);
    chk("r037 ovf", ovf, 0);

    // Both-edge mode on ch1, intervals 10,20,30,40
    edge_mode = 4'b1101;
    base1 = stb_tot1;
    tog(1, 10);
    tog(1, 20);
    tog(1, 30);
    tog(1, 40);
    tog(1, 5);
    chk("r038 slot0", slot(1, 0), 40);
    chk("r038 slot1", slot(1, 1), 30);
    chk("r038 slot2", slot(1, 2), 20);
    chk("r038 valid_cnt", vc(1), 3);
    chk("r038 stb count", stb_tot1 - base1, 4);
    chk("r038 ch0 untouched", slot(0, 0), 100);

    // Saturation and sticky overflow on ch0
    clr = 2'b01;
    @(posedge clk);
    #1 clr = 2'b00;
    gap(0, 300);
    gap(0, 300);
    chk("r039 slot0 saturated", slot(0, 0), 255);
    chk("r039 ovf0", ovf[0], 1);
    chk("r039 ovf1", ovf[1], 0);
    chk("r039 valid_cnt", vc(0), 1);
    clr = 2'b01;
    @(posedge clk);
    #1 clr = 2'b00;
    chk("r039 clr ovf", ovf[0], 0);
    chk("r039 clr valid_cnt", vc(0), 0);
    chk("r039 clr slot0", slot(0, 0), 0);
    chk("r039 ch1 kept", slot(1, 0), 40);

    // clr on ch1 coinciding with its edge_evt while ch0 pushes
    gap(0, 30);
    d[0] = 1'b1;
    d[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 2'b10;
    #1;
    chk("r040 edge_evt both", edge_evt, 2'b11);
    chk("r040 stb ch0 only", stb, 2'b01);
    @(posedge clk);
    #1 clr = 2'b00;
    chk("r040 edge_evt one clk", edge_evt, 0);
    chk("r040 ch0 valid_cnt", vc(0), 1);
    chk("r040 ch0 slot0", slot(0, 0), 30);
    chk("r040 ch1 valid_cnt", vc(1), 0);
    chk("r040 ch1 slot0", slot(1, 0), 0);
    tog(1, 15);
    tog(1, 5);
    chk("r040 ch1 rearm valid_cnt", vc(1), 1);
    chk("r040 ch1 rearm slot0", slot(1, 0), 15);

    // Asynchronous reset mid-measurement
    #3;
    rst = 1'b0;
    d = 2'b00;
    #1;
    chk("r041 filtered", filtered, 0);
    chk("r041 edge_evt", edge_evt, 0);
    chk("r041 stb", stb, 0);
    chk("r041 period", period, 0);
    chk("r041 valid_cnt", valid_cnt, 0);
    chk("r041 ovf", ovf, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    base0 = stb_tot0;
    gap(0, 40);
    chk("r041 first edge arms only", vc(0), 0);
    chk("r041 no stb on arm", stb_tot0 - base0, 0);
    gap(0, 40);
    chk("r041 valid_cnt", vc(0), 1);
    chk("r041 slot0", slot(0, 0), 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
